flags_reg: RTL and testbench

//  Architectural FLAGS register sitting directly downstream of the ALU.
//  - Commits ALU flags_out under a per-op bit mask.
//  - Applies CLI/STI/CLD/STD/CMC-free direct set/clear of IF and DF.
//  - Feeds the current FLAGS value back to the ALU flags_in port.
//  - Tracks the STI interrupt shadow and the TF single-step trap at

---
 rtl/flags_reg.sv | 105 ++++++++++
 tb/tb_flags_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/flags_reg.sv
// Architectural FLAGS register behind the ALU: masked commits, IF/DF overrides,
// STI interrupt shadow and TF single-step trap tracking at instruction boundaries.
module flags_reg #(
  parameter logic [15:0] RESERVED_ONES = 16'hF002,
  parameter logic [15:0] WRITABLE_MASK = 16'h0FD5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] alu_flags,
  input  logic        update_valid,
  input  logic [15:0] update_mask,
  input  logic        set_if,
  input  logic        clr_if,
  input  logic        set_df,
  input  logic        clr_df,
  input  logic        instr_start,
  input  logic        instr_done,
  input  logic        trap_ack,
  output logic [15:0] flags,
  output logic        irq_enable,
  output logic        trap_pending
);

  localparam int TF_BIT = 8;
  localparam int IF_BIT = 9;
  localparam int DF_BIT = 10;

  logic [15:0] store_q, store_d;
  logic [15:0] commit_mask;
  logic [1:0]  shadow_q, shadow_d;
  logic        irq_q, irq_d;
  logic        tf_latched_q, tf_latched_d;
  logic        trap_q, trap_d;
  logic        tf_eff;

  assign commit_mask = update_mask & WRITABLE_MASK;

  // ALU commit first, then the direct IF/DF controls override; clear beats set.
  always_comb begin
    store_d = store_q;
    if (update_valid) begin
      store_d = (store_q & ~commit_mask) | (alu_flags & commit_mask);
    end
    if (clr_df) begin
      store_d[DF_BIT] = 1'b0;
    end else if (set_df) begin
      store_d[DF_BIT] = 1'b1;
    end
    if (clr_if) begin
      store_d[IF_BIT] = 1'b0;
    end else if (set_if) begin
      store_d[IF_BIT] = 1'b1;
    end
  end

  // The STI instruction's own instr_done consumes one count, so interrupts
  // open only after the following instruction completes.
  always_comb begin
    shadow_d = shadow_q;
    if (clr_if) begin
      shadow_d = 2'd0;
    end else if (set_if) begin
      shadow_d = instr_done ? 2'd1 : 2'd2;
    end else if (instr_done && (shadow_q != 2'd0)) begin
      shadow_d = shadow_q - 2'd1;
    end
  end

  assign irq_d = store_d[IF_BIT] && (shadow_d == 2'd0);

  // TF is sampled pre-update at instruction start, so POPF/IRET setting TF
  // does not trap on itself.
  assign tf_eff       = instr_start ? store_q[TF_BIT] : tf_latched_q;
  assign tf_latched_d = instr_start ? store_q[TF_BIT] : tf_latched_q;

  always_comb begin
    trap_d = trap_q;
    if (instr_done && tf_eff) begin
      trap_d = 1'b1;
    end else if (trap_ack) begin
      trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_q      <= 16'h0000;
      shadow_q     <= 2'd0;
      irq_q        <= 1'b0;
      tf_latched_q <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      store_q      <= store_d;
      shadow_q     <= shadow_d;
      irq_q        <= irq_d;
      tf_latched_q <= tf_latched_d;
      trap_q       <= trap_d;
    end
  end

  assign flags        = (store_q & WRITABLE_MASK) | RESERVED_ONES;
  assign irq_enable   = irq_q;
  assign trap_pending = trap_q;

endmodule

// File: tb/tb_flags_reg.sv
// Directed bench for flags_reg with hand-computed expected values.
module tb_flags_reg;

  logic        clk;
  logic        reset_n;
  logic [15:0] alu_flags;
  logic        update_valid;
  logic [15:0] update_mask;
  logic        set_if, clr_if, set_df, clr_df;
  logic        instr_start, instr_done, trap_ack;
  logic [15:0] flags;
  logic        irq_enable;
  logic        trap_pending;

  int n_tests = 0;
  int n_fail  = 0;

  flags_reg dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_flags    (alu_flags),
    .update_valid (update_valid),
    .update_mask  (update_mask),
    .set_if       (set_if),
    .clr_if       (clr_if),
    .set_df       (set_df),
    .clr_df       (clr_df),
    .instr_start  (instr_start),
    .instr_done   (instr_done),
    .trap_ack     (trap_ack),
    .flags        (flags),
    .irq_enable   (irq_enable),
    .trap_pending (trap_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_flags    = 16'h0000;
    update_valid = 1'b0;
    update_mask  = 16'h0000;
    set_if       = 1'b0;
    clr_if       = 1'b0;
    set_df       = 1'b0;
    clr_df       = 1'b0;
    instr_start  = 1'b0;
    instr_done   = 1'b0;
    trap_ack     = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [15:0] mask, input logic [15:0] val);
    update_valid = 1'b1;
    update_mask  = mask;
    alu_flags    = val;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #2;
    check("rst_flags", 32'(flags), 32'hF002);
    check("rst_irq", 32'(irq_enable), 32'h0);
    check("rst_trap", 32'(trap_pending), 32'h0);
    #10 reset_n = 1'b1;
    cyc();

    // Masked commit of CF only, then a write to reserved bit 12
    commit(16'h0001, 16'hFFFF); cyc(); idle();
    check("mask_cf", 32'(flags), 32'hF003);
    commit(16'h1000, 16'hFFFF); cyc(); idle();
    check("bit12_write", 32'(flags), 32'hF003);

    // Back-to-back commits on consecutive cycles
    commit(16'h0001, 16'h0000); cyc();
    check("b2b_0", 32'(flags), 32'hF002);
    commit(16'h0001, 16'h0001); cyc();
    check("b2b_1", 32'(flags), 32'hF003);
    commit(16'h0001, 16'h0000); cyc(); idle();
    check("b2b_2", 32'(flags), 32'hF002);

    // Full-mask commit of arithmetic flags, then clear
    commit(16'hFFFF, 16'h08D5); cyc(); idle();
    check("arith_flags", 32'(flags), 32'hF8D7);
    check("arith_irq", 32'(irq_enable), 32'h0);
    commit(16'hFFFF, 16'h0000); cyc(); idle();
    check("arith_clear", 32'(flags), 32'hF002);

    // STI completing in one cycle, then a 4-cycle instruction
    set_if = 1'b1; instr_start = 1'b1; instr_done = 1'b1; cyc(); idle();
    check("sti_flags", 32'(flags), 32'hF202);
    check("sti_irq0", 32'(irq_enable), 32'h0);
    instr_start = 1'b1; cyc(); idle();
    check("sti_irq1", 32'(irq_enable), 32'h0);
    cyc();
    check("sti_irq2", 32'(irq_enable), 32'h0);
    cyc();
    check("sti_irq3", 32'(irq_enable), 32'h0);
    instr_done = 1'b1; cyc(); idle();
    check("sti_irq_on", 32'(irq_enable), 32'h1);

    // Conflicting IF controls plus a commit setting IF
    set_if = 1'b1; clr_if = 1'b1; commit(16'h0200, 16'h0200); cyc(); idle();
    check("conf_flags", 32'(flags), 32'hF002);
    check("conf_irq", 32'(irq_enable), 32'h0);
    check("conf_shadow", 32'(dut.shadow_q), 32'h0);
    commit(16'h0200, 16'h0200); cyc(); idle();
    check("popf_if_irq", 32'(irq_enable), 32'h1);
    check("popf_if_flags", 32'(flags), 32'hF202);

    // DF controls
    set_df = 1'b1; cyc(); idle();
    check("std", 32'(flags), 32'hF602);
    set_df = 1'b1; clr_df = 1'b1; cyc(); idle();
    check("std_cld", 32'(flags), 32'hF202);
    clr_if = 1'b1; cyc(); idle();
    check("cli_flags", 32'(flags), 32'hF002);
    check("cli_irq", 32'(irq_enable), 32'h0);

    // Single-step: POPF sets TF without trapping itself
    instr_start = 1'b1; cyc(); idle();
    commit(16'h0100, 16'h0100); instr_done = 1'b1; cyc(); idle();
    check("popf_tf", 32'(flags), 32'hF102);
    check("popf_notrap", 32'(trap_pending), 32'h0);
    instr_start = 1'b1; cyc(); idle();
    check("ss_start", 32'(trap_pending), 32'h0);
    instr_done = 1'b1; cyc(); idle();
    check("ss_trap", 32'(trap_pending), 32'h1);
    cyc();
    check("ss_hold", 32'(trap_pending), 32'h1);
    trap_ack = 1'b1; cyc(); idle();
    check("ss_ack", 32'(trap_pending), 32'h0);
    instr_start = 1'b1; instr_done = 1'b1; cyc(); idle();
    check("ss_onecyc", 32'(trap_pending), 32'h1);
    trap_ack = 1'b1; instr_start = 1'b1; instr_done = 1'b1; cyc(); idle();
    check("ss_set_wins", 32'(trap_pending), 32'h1);
    trap_ack = 1'b1; cyc(); idle();
    check("ss_ack2", 32'(trap_pending), 32'h0);
    clr_if = 1'b1; commit(16'h0100, 16'h0000); cyc(); idle();
    check("trap_entry", 32'(flags), 32'hF002);

    // Asynchronous reset mid-cycle with live state
    commit(16'h0300, 16'h0300); cyc(); idle();
    check("pre_rst_flags", 32'(flags), 32'hF302);
    check("pre_rst_irq", 32'(irq_enable), 32'h1);
    instr_start = 1'b1; instr_done = 1'b1; cyc(); idle();
    check("pre_rst_trap", 32'(trap_pending), 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_flags", 32'(flags), 32'hF002);
    check("arst_irq", 32'(irq_enable), 32'h0);
    check("arst_trap", 32'(trap_pending), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
